// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, ALU ops, FSM states and mux selects.
package mc_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic ADDR_SEL_PC   = 1'b0;
  localparam logic ADDR_SEL_IR   = 1'b1;
  localparam logic PC_SEL_INC    = 1'b0;
  localparam logic PC_SEL_ADDR   = 1'b1;
  localparam logic WSEL_ALU      = 1'b0;
  localparam logic WSEL_MEM      = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Non-ALU opcodes map to ADD so the ALU sees a benign operation.
  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Memory request/ready handshake between the control FSM and the memory port.
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles; flags when the count has reached MEM_TIMEOUT.
module mc_wait_timer #(
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  output logic expired
);

  localparam logic [TMO_W-1:0] Limit = TMO_W'(MEM_TIMEOUT);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Any non-waiting cycle clears the count, so each new request starts from zero.
  always_comb begin
    cnt_d = '0;
    if (wait_en) begin
      cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing with memory timeout.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         opcode,
  mc_control_fsm_if.master   mem,
  output logic               ir_load,
  output logic               pc_en,
  output logic               pc_sel,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [1:0]         alu_op,
  output logic               retired,
  output logic [COUNT_W-1:0] instr_count,
  output logic               halted,
  output logic               mem_err
);

  state_e             state_q, state_d;
  logic [2:0]         opcode_q, opcode_d;
  logic [COUNT_W-1:0] count_q;
  logic               err_q, err_set;
  logic               req, we, addr_sel;
  logic               tmo_expired;

  mc_wait_timer #(
    .TMO_W       (TMO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wait_en (req && !mem.mem_ready),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    req      = 1'b0;
    we       = 1'b0;
    addr_sel = ADDR_SEL_PC;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_SEL_INC;
    rf_we    = 1'b0;
    rf_wsel  = WSEL_ALU;
    alu_op   = ALU_ADD;
    retired  = 1'b0;
    halted   = 1'b0;
    err_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        req      = 1'b1;
        addr_sel = ADDR_SEL_PC;
        if (mem.mem_ready) begin
          ir_load = 1'b1;
          pc_en   = 1'b1;
          pc_sel  = PC_SEL_INC;
          state_d = S_DECODE;
        end else if (tmo_expired) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      // Routing here follows the live opcode; later states rely on opcode_q.
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_NOP: begin
            retired = 1'b1;
            state_d = S_FETCH;
          end
          OP_JUMP: begin
            pc_en   = 1'b1;
            pc_sel  = PC_SEL_ADDR;
            retired = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            retired = 1'b1;
            state_d = S_HALT;
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_op  = alu_op_of(opcode_q);
        state_d = S_WB;
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = ADDR_SEL_IR;
        we       = (opcode_q == OP_STORE);
        if (mem.mem_ready) begin
          if (opcode_q == OP_STORE) begin
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_expired) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = (opcode_q == OP_LOAD) ? WSEL_MEM : WSEL_ALU;
        alu_op  = alu_op_of(opcode_q);
        retired = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_NOP;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      if (retired) count_q <= count_q + COUNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign mem.mem_req      = req;
  assign mem.mem_we       = we;
  assign mem.mem_addr_sel = addr_sel;
  assign instr_count      = count_q;
  assign mem_err          = err_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with COUNT_W=4 and MEM_TIMEOUT=4.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic       ir_load, pc_en, pc_sel, rf_we, rf_wsel, retired, halted, mem_err;
  logic [1:0] alu_op;
  logic [3:0] instr_count;

  int checks   = 0;
  int failures = 0;

  mc_control_fsm_if mif ();

  mc_control_fsm #(
    .COUNT_W     (4),
    .TMO_W       (8),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .mem         (mif.master),
    .ir_load     (ir_load),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .alu_op      (alu_op),
    .retired     (retired),
    .instr_count (instr_count),
    .halted      (halted),
    .mem_err     (mem_err)
  );

  // {req, we, asel, ir_load, pc_en, pc_sel, rf_we, rf_wsel, alu_op, retired, halted, mem_err}
  wire [12:0] outs = {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_load, pc_en, pc_sel,
                      rf_we, rf_wsel, alu_op, retired, halted, mem_err};

  localparam logic [12:0] O_NONE   = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] O_FWAIT  = 13'b1_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] O_FDONE  = 13'b1_0_0_1_1_0_0_0_00_0_0_0;
  localparam logic [12:0] O_MEMRD  = 13'b1_0_1_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] O_MEMWR  = 13'b1_1_1_0_0_0_0_0_00_1_0_0;
  localparam logic [12:0] O_WBLD   = 13'b0_0_0_0_0_0_1_1_00_1_0_0;
  localparam logic [12:0] O_WBADD  = 13'b0_0_0_0_0_0_1_0_00_1_0_0;
  localparam logic [12:0] O_EXSUB  = 13'b0_0_0_0_0_0_0_0_01_0_0_0;
  localparam logic [12:0] O_WBSUB  = 13'b0_0_0_0_0_0_1_0_01_1_0_0;
  localparam logic [12:0] O_EXAND  = 13'b0_0_0_0_0_0_0_0_10_0_0_0;
  localparam logic [12:0] O_WBAND  = 13'b0_0_0_0_0_0_1_0_10_1_0_0;
  localparam logic [12:0] O_JUMP   = 13'b0_0_0_0_1_1_0_0_00_1_0_0;
  localparam logic [12:0] O_RET    = 13'b0_0_0_0_0_0_0_0_00_1_0_0;
  localparam logic [12:0] O_HALT   = 13'b0_0_0_0_0_0_0_0_00_0_1_0;
  localparam logic [12:0] O_HALTER = 13'b0_0_0_0_0_0_0_0_00_0_1_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int saw_req;

    // Reset: Mealy outputs stay low even with mem_ready and start high.
    rst_n = 1'b0; start = 1'b1; opcode = 3'b011; mif.mem_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outs", 32'(outs), 32'(O_NONE));
    chk("reset_count", 32'(instr_count), 32'd0);

    // ADD with zero wait states.
    rst_n = 1'b1; #1;
    chk("idle_outs", 32'(outs), 32'(O_NONE));
    tick(); start = 1'b0; #1;
    chk("add_fetch", 32'(outs), 32'(O_FDONE));
    tick(); chk("add_decode", 32'(outs), 32'(O_NONE));
    tick(); chk("add_exec", 32'(outs), 32'(O_NONE));
    tick(); chk("add_wb", 32'(outs), 32'(O_WBADD));
    tick(); chk("add_count", 32'(instr_count), 32'd1);

    // LOAD with two wait states in MEM.
    opcode = 3'b001; #1;
    chk("ld_fetch", 32'(outs), 32'(O_FDONE));
    tick(); mif.mem_ready = 1'b0; #1;
    chk("ld_decode", 32'(outs), 32'(O_NONE));
    tick(); chk("ld_mem_w1", 32'(outs), 32'(O_MEMRD));
    tick(); chk("ld_mem_w2", 32'(outs), 32'(O_MEMRD));
    tick(); mif.mem_ready = 1'b1; #1;
    chk("ld_mem_done", 32'(outs), 32'(O_MEMRD));
    tick(); chk("ld_wb", 32'(outs), 32'(O_WBLD));
    tick(); chk("ld_count", 32'(instr_count), 32'd2);

    // STORE: write strobe in MEM, retires on completion.
    opcode = 3'b010; #1;
    chk("st_fetch", 32'(outs), 32'(O_FDONE));
    tick(); chk("st_decode", 32'(outs), 32'(O_NONE));
    tick(); chk("st_mem", 32'(outs), 32'(O_MEMWR));
    tick(); chk("st_count", 32'(instr_count), 32'd3);

    // JUMP retires in DECODE with PC load from the address field.
    opcode = 3'b110; #1;
    chk("jmp_fetch", 32'(outs), 32'(O_FDONE));
    tick(); chk("jmp_decode", 32'(outs), 32'(O_JUMP));
    tick(); chk("jmp_count", 32'(instr_count), 32'd4);

    // SUB: alu_op comes from the captured opcode, not the live input.
    opcode = 3'b100;
    tick(); tick(); opcode = 3'b101; #1;
    chk("sub_exec", 32'(outs), 32'(O_EXSUB));
    tick(); chk("sub_wb", 32'(outs), 32'(O_WBSUB));
    tick(); chk("sub_count", 32'(instr_count), 32'd5);

    // AND.
    tick(); tick(); chk("and_exec", 32'(outs), 32'(O_EXAND));
    tick(); chk("and_wb", 32'(outs), 32'(O_WBAND));
    tick(); chk("and_count", 32'(instr_count), 32'd6);

    // Async reset in the middle of a MEM wait.
    opcode = 3'b001;
    tick(); mif.mem_ready = 1'b0;
    tick(); chk("rst_pre_mem", 32'(outs), 32'(O_MEMRD));
    #2; rst_n = 1'b0; #1;
    chk("rst_async_outs", 32'(outs), 32'(O_NONE));
    chk("rst_async_count", 32'(instr_count), 32'd0);
    tick(); rst_n = 1'b1;
    tick(); chk("rst_idle_outs", 32'(outs), 32'(O_NONE));
    chk("rst_idle_err", 32'(mem_err), 32'd0);

    // Fetch completes on the cycle the wait count hits the limit.
    opcode = 3'b000; start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("tmo_edge_wait", 32'(outs), 32'(O_FWAIT));
    repeat (4) tick();
    mif.mem_ready = 1'b1; #1;
    chk("tmo_edge_done", 32'(outs), 32'(O_FDONE));
    tick(); chk("tmo_edge_nop", 32'(outs), 32'(O_RET));
    tick();

    // 16 more NOPs: 17 total wraps a 4-bit count to 1.
    for (int i = 0; i < 16; i++) begin
      tick(); chk($sformatf("nop_ret_%0d", i), 32'(retired), 32'd1);
      tick();
    end
    chk("wrap_count", 32'(instr_count), 32'd1);

    // HALT opcode retires in DECODE then parks.
    opcode = 3'b111;
    tick(); chk("halt_decode", 32'(outs), 32'(O_RET));
    tick(); chk("halt_state", 32'(outs), 32'(O_HALT));
    chk("halt_count", 32'(instr_count), 32'd2);
    saw_req = 0;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      tick();
      if (mif.mem_req) saw_req++;
    end
    start = 1'b0;
    chk("halt_no_req", 32'(saw_req), 32'd0);
    chk("halt_hold", 32'(outs), 32'(O_HALT));
    chk("halt_count_hold", 32'(instr_count), 32'd2);

    // Fetch timeout: request held through MEM_TIMEOUT+1 cycles, then error halt.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mif.mem_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0; #1;
    n = 0;
    while (mif.mem_req && n < 20) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", 32'(n), 32'd5);
    chk("tmo_outs", 32'(outs), 32'(O_HALTER));
    chk("tmo_count", 32'(instr_count), 32'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("tmo_start_ignored", 32'(outs), 32'(O_HALTER));

    rst_n = 1'b0; #1;
    chk("tmo_reset_clears", 32'(outs), 32'(O_NONE));
    tick(); rst_n = 1'b1; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
